fib_seg_display: RTL and testbench

FIB_SEG_DISPLAY -- requirements
Module: fib_seg_display

---
 rtl/fib_pkg.sv | 49 ++++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/fib_seg_display.sv | 172 +++++++++++++++++
 tb/tb_fib_seg_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// ----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci seven-segment display block:
//   - FSM state encoding (SEED / RUN / HOLD)
//   - seed values for the sequence registers (a = previous term, b = current)
//   - active-high seven-segment glyph table, bit order {g,f,e,d,c,b,a}
// No ports (package).
// ----------------------------------------------------------------------------
package fib_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_SEED = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Sequence seed: a = 0, b = 1. SEED_B must fit in one hex nibble so the
    // reset glyph pattern (digit 0 only) stays correct.
    localparam int SEED_A = 0;
    localparam int SEED_B = 1;

    // Glyphs, {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;  // lower-case b
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;  // lower-case d
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    // Table indexed by nibble value (entry 15 listed first)
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] hex);
        return SEG_GLYPHS[hex];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to seven-segment decoder (0-9, A, b, C, d, E, F).
// Ports:
//   hex  in  [3:0]  nibble to display
//   seg  out [6:0]  active-high segments {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import fib_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = seg_glyph(hex);

endmodule

// File: rtl/fib_seg_display.sv
// ----------------------------------------------------------------------------
// fib_seg_display
// Steps a Fibonacci sequence once every DIV clocks (or on a single-step
// request while paused) and shows the current term on DIGITS hex
// seven-segment digits through a registered decoder.
//
// Parameters:
//   WIDTH   sequence width in bits (multiple of 4, 4..32)
//   DIV     clk cycles per sequence step (>= 2)
//   DIGITS  number of hex digits driven (default WIDTH/4)
// Ports:
//   clk          in   single clock, rising edge
//   RST          in   synchronous active-high reset, overrides everything
//   en           in   1 = free-running stepping, 0 = paused
//   mode         in   overflow policy: 0 = wrap to seed, 1 = hold
//   step_req     in   single-step pulse, only honoured while en = 0
//   seq          out  [WIDTH-1:0] current term
//   step         out  one-cycle pulse in the cycle seq advances
//   ovf          out  sticky overflow flag, cleared only by RST
//   Segment_out  out  [7*DIGITS-1:0] digit k on bits [7k+6:7k], {g..a}
// Build option:
//   FIB_LZ_BLANK_EN  blank leading-zero digits (digit 0 never blanks)
// ----------------------------------------------------------------------------
module fib_seg_display
    import fib_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIV    = 24000000,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  step_req,
    output logic [WIDTH-1:0]      seq,
    output logic                  step,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   Segment_out
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

    // ------------------------------------------------------------------
    // Step divider / tick generation
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_hit;
    logic             tick;

    assign div_hit = (div_cnt == DIV_W'(DIV - 1));
    // Free-running ticks while enabled; manual single step while paused.
    assign tick    = en ? div_hit : step_req;

    // ------------------------------------------------------------------
    // Sequence FSM
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;

    // One extra bit so the carry out flags a term that no longer fits.
    assign sum = {1'b0, a_q} + {1'b0, b_q};
    assign seq = b_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            div_cnt <= '0;
            state   <= ST_SEED;
            a_q     <= WIDTH'(SEED_A);
            b_q     <= WIDTH'(SEED_B);
            step    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (en)
                div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);

            step <= 1'b0;
            case (state)
                ST_SEED: begin
                    // Reloading the seed is not a step, even if seq changes.
                    a_q   <= WIDTH'(SEED_A);
                    b_q   <= WIDTH'(SEED_B);
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        if (!sum[WIDTH]) begin
                            a_q  <= b_q;
                            b_q  <= sum[WIDTH-1:0];
                            step <= 1'b1;
                        end else begin
                            ovf   <= 1'b1;
                            state <= mode ? ST_HOLD : ST_SEED;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!mode)
                        state <= ST_SEED;
                end
                default: state <= ST_SEED;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display decode
    // ------------------------------------------------------------------
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0][6:0] glyph;
    logic [DIGITS-1:0][6:0] seg_d;
    logic [DIGITS-1:0][6:0] seg_rst;
    logic [DIGITS-1:0][6:0] seg_q;

    // Digits beyond the sequence width show a zero nibble.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        if ((4 * k + 3) < WIDTH) begin : g_nib
            assign nib[k] = b_q[4*k+3:4*k];
        end else begin : g_pad
            assign nib[k] = 4'h0;
        end

        seg7_hex_decode u_dec (
            .hex (nib[k]),
            .seg (glyph[k])
        );
    end

`ifdef FIB_LZ_BLANK_EN
    // lit[k] is set when digit k or any digit above it is non-zero.
    logic [DIGITS-1:0] lit;
    logic              nz_seen;

    always_comb begin
        lit     = '0;
        nz_seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_seen = nz_seen | (nib[k] != 4'h0);
            lit[k]  = nz_seen | (k == 0);
        end
    end

    always_comb begin
        seg_d   = '0;
        seg_rst = '0;
        for (int k = 0; k < DIGITS; k++)
            seg_d[k] = lit[k] ? glyph[k] : 7'b0;
        seg_rst[0] = seg_glyph(4'(SEED_B));
    end
`else
    always_comb begin
        seg_d   = glyph;
        seg_rst = '0;
        for (int k = 0; k < DIGITS; k++)
            seg_rst[k] = (k == 0) ? seg_glyph(4'(SEED_B)) : seg_glyph(4'h0);
    end
`endif

    // Registered display: follows seq with one cycle of latency. On reset
    // it shows the seed directly so the digits are valid immediately.
    always_ff @(posedge clk) begin
        if (RST)
            seg_q <= seg_rst;
        else
            seg_q <= seg_d;
    end

    assign Segment_out = seg_q;

endmodule

// File: tb/tb_fib_seg_display.sv
// Bench for fib_seg_display (WIDTH=8, DIV=4): directed phases followed by
// random stimulus, every cycle compared with a behavioural reference model.
module tb_fib_seg_display;

    localparam int WIDTH  = 8;
    localparam int DIV    = 4;
    localparam int DIGITS = 2;

    logic                clk = 1'b0;
    logic                RST = 1'b1;
    logic                en = 1'b0;
    logic                mode = 1'b0;
    logic                step_req = 1'b0;
    logic [WIDTH-1:0]    seq;
    logic                step;
    logic                ovf;
    logic [7*DIGITS-1:0] Segment_out;

    always #5 clk = ~clk;

    fib_seg_display #(.WIDTH(WIDTH), .DIV(DIV), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .RST         (RST),
        .en          (en),
        .mode        (mode),
        .step_req    (step_req),
        .seq         (seq),
        .step        (step),
        .ovf         (ovf),
        .Segment_out (Segment_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: terms as plain integers, a phase counter for the
    // divider, and flags for "reseeding next cycle" / "holding".
    int             m_div = 0;
    int             m_a = 0;
    int             m_b = 1;
    bit             m_step = 0;
    bit             m_ovf = 0;
    bit             m_seeding = 1;
    bit             m_holding = 0;
    logic [13:0]    m_seg = '0;

    logic [6:0] glyph_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [13:0] disp(input int v);
        logic [13:0] r;
        int part;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            part = v >> (4 * k);
            r[7*k +: 7] = glyph_tbl[part & 15];
`ifdef FIB_LZ_BLANK_EN
            if (k > 0 && part == 0) r[7*k +: 7] = 7'b0;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the state after the coming rising edge from the current inputs.
    task automatic model_step();
        bit tick;
        if (RST) begin
            m_div = 0; m_a = 0; m_b = 1; m_step = 0; m_ovf = 0;
            m_seeding = 1; m_holding = 0;
            m_seg = disp(1);
        end else begin
            m_seg = disp(m_b);
            tick = en ? (m_div == DIV - 1) : step_req;
            if (en) m_div = (m_div + 1) % DIV;
            m_step = 0;
            if (m_seeding) begin
                m_a = 0; m_b = 1; m_seeding = 0;
            end else if (m_holding) begin
                if (!mode) begin m_holding = 0; m_seeding = 1; end
            end else if (tick) begin
                if (m_a + m_b < (1 << WIDTH)) begin
                    int s;
                    s = m_a + m_b; m_a = m_b; m_b = s; m_step = 1;
                end else begin
                    m_ovf = 1;
                    if (mode) m_holding = 1; else m_seeding = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("seq", seq, m_b);
        chk("step", step, m_step);
        chk("ovf", ovf, m_ovf);
        chk("seg", Segment_out, m_seg);
    endtask

    task automatic wait_seq(input int target, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc();
            if (step && seq == target) found = 1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_seq: step to %0d not seen in %0d cycles, observed seq %0d", target, budget, seq);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    int exp_seq [13] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 1};
    int got_seq [$];
    int step_cyc [$];
    logic [6:0] exp_hi;

    initial begin
        // Reset state
        en = 1'b1; mode = 1'b0;
        do_reset();
        chk("rst_seq", seq, 1);
        chk("rst_step", step, 0);
        chk("rst_ovf", ovf, 0);
`ifdef FIB_LZ_BLANK_EN
        chk("rst_seg", Segment_out, {7'b0000000, 7'b0000110});
`else
        chk("rst_seg", Segment_out, {7'b0111111, 7'b0000110});
`endif

        // Stepping with wrap-around
        for (int i = 0; i < 80 && got_seq.size() < 13; i++) begin
            cyc();
            if (step) begin got_seq.push_back(seq); step_cyc.push_back(i); end
        end
        chk("wrap_count", got_seq.size(), 13);
        for (int i = 0; i < 13 && i < got_seq.size(); i++)
            chk($sformatf("seq_term%0d", i), got_seq[i], exp_seq[i]);
        if (step_cyc.size() >= 2) chk("step_period", step_cyc[1] - step_cyc[0], 4);
        chk("first_step_cycle", step_cyc.size() > 0 ? step_cyc[0] : -1, 3);
        chk("wrap_ovf_sticky", ovf, 1);

        // Mid-operation reset on the tick that would produce 34 after 21
        wait_seq(21, 40);
        cyc(); cyc(); cyc();
        RST = 1'b1;
        cyc();
        chk("midrst_step", step, 0);
        chk("midrst_seq", seq, 1);
        chk("midrst_ovf", ovf, 0);
        RST = 1'b0;
        cyc(); cyc(); cyc();
        chk("midrst_nostep", step, 0);
        cyc();
        chk("midrst_restart", step, 1);

        // Overflow with hold
        mode = 1'b1;
        do_reset();
        wait_seq(233, 80);
        for (int i = 0; i < 20; i++) cyc();
        chk("hold_seq", seq, 233);
        chk("hold_ovf", ovf, 1);
        mode = 1'b0;
        cyc(); cyc();
        chk("hold_release_seq", seq, 1);

        // Pause and single step
        do_reset();
        wait_seq(5, 40);
        en = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("pause_seq", seq, 5);
        step_req = 1'b1;
        cyc();
        chk("single_step", step, 1);
        chk("single_seq", seq, 8);
        step_req = 1'b0;
        cyc();
        chk("single_once", step, 0);
        en = 1'b1;

        // Display of 0x0D with one cycle of latency
        wait_seq(13, 40);
        chk("seg_latency", Segment_out[6:0], 7'b1111111);
        cyc();
`ifdef FIB_LZ_BLANK_EN
        exp_hi = 7'b0000000;
`else
        exp_hi = 7'b0111111;
`endif
        chk("seg_d_lo", Segment_out[6:0], 7'b1011110);
        chk("seg_d_hi", Segment_out[13:7], exp_hi);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) mode = ~mode;
            step_req = ($urandom_range(0, 3) == 0);
            RST = ($urandom_range(0, 300) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
